// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forward-select codes and the hard-wired zero register.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A later stage supplies src when it writes a non-zero register equal to src.
  function automatic logic regHit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: latch fields in, stall/flush/forward controls out.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs, id_rt;
  logic [4:0]       ex_rs, ex_rt, ex_dst;
  logic             ex_mem_read;
  logic [4:0]       mem_dst, wb_dst;
  logic             mem_reg_write, wb_reg_write;
  logic             mem_br_taken;
  logic             pc_write, ifid_write, idex_bubble;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_dst, ex_mem_read,
           mem_dst, mem_reg_write, wb_dst, wb_reg_write, mem_br_taken,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_dst, ex_mem_read,
           mem_dst, mem_reg_write, wb_dst, wb_reg_write, mem_br_taken,
    output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// ALU operand source select for one operand; EX/MEM result beats MEM/WB data.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] srcReg,
  input  logic [4:0] memDst,
  input  logic       memRegWrite,
  input  logic [4:0] wbDst,
  input  logic       wbRegWrite,
  output logic [1:0] fwdSel
);

  always_comb begin
    fwdSel = FWD_REG;
    if (regHit(memRegWrite, memDst, srcReg))
      fwdSel = FWD_MEM;
    else if (regHit(wbRegWrite, wbDst, srcReg))
      fwdSel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, branch flush and operand forwarding control for a 5-stage pipeline,
// with saturating stall/flush event counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           stateQ, stateD;
  logic             lu, br, stallEvt;
  logic [1:0]       selA, selB;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  fwd_select u_fwdA (
    .srcReg      (hz.ex_rs),
    .memDst      (hz.mem_dst),
    .memRegWrite (hz.mem_reg_write),
    .wbDst       (hz.wb_dst),
    .wbRegWrite  (hz.wb_reg_write),
    .fwdSel      (selA)
  );

  fwd_select u_fwdB (
    .srcReg      (hz.ex_rt),
    .memDst      (hz.mem_dst),
    .memRegWrite (hz.mem_reg_write),
    .wbDst       (hz.wb_dst),
    .wbRegWrite  (hz.wb_reg_write),
    .fwdSel      (selB)
  );

  // Hazard terms are gated by rst_n so every control output is benign while in reset.
  always_comb begin
    lu = rst_n && hz.ex_mem_read && (hz.ex_dst != REG_ZERO)
         && ((hz.ex_dst == hz.id_rs) || (hz.ex_dst == hz.id_rt))
         && (stateQ != FLUSH);
    br       = rst_n && hz.mem_br_taken;
    stallEvt = lu && !br;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= RUN;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD         = stateQ;
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.idex_bubble = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_flush = 1'b0;

    if (br) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
      hz.exmem_flush = 1'b1;
    end else if (stallEvt) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
    end

    unique case (stateQ)
      RUN:     stateD = br ? FLUSH : (lu ? STALL : RUN);
      STALL:   stateD = br ? FLUSH : RUN;
      FLUSH:   stateD = RUN;
      default: stateD = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallEvt && (stallCnt != '1)) stallCnt <= stallCnt + CNT_ONE;
      if (br && (flushCnt != '1))       flushCnt <= flushCnt + CNT_ONE;
    end
  end

  always_comb begin
    hz.fwd_a     = rst_n ? selA : FWD_REG;
    hz.fwd_b     = rst_n ? selB : FWD_REG;
    hz.state     = stateQ;
    hz.stall_cnt = stallCnt;
    hz.flush_cnt = flushCnt;
  end

endmodule
